// File: rtl/cxapbasyncbridge_slv_hs_ctrl.sv
// ---------------------------------------------------------------------------
// cxapbasyncbridge_slv_hs_ctrl
//   Slave-side transfer sequencer of the APB asynchronous bridge (PCLKS domain).
//   Accepts one APB3 transfer at a time, holds address/data/direction stable,
//   launches the transfer to the master domain as a toggle request and waits
//   for the synchronised toggle acknowledge before completing the APB access
//   with the returned read data / error response.
//
// Ports
//   PCLKS, PRESETSn          slave clock, async active-low reset
//   PSELS/PENABLES/PWRITES   APB control
//   PADDRS/PWDATAS           APB address / write data
//   PRDATAS/PREADYS/PSLVERRS APB response (all registered)
//   req_tgl                  request toggle to master domain
//   req_addr/wdata/write     held request, stable from req_tgl flip until ack
//   ack_tgl_async            ack toggle from master domain (unsynchronised)
//   ack_rdata/ack_slverr     response, stable before ack toggles
//   spurious_ack             sticky: ack event seen with no request pending
//   state_dbg_o              current FSM state (0 IDLE, 1 WAIT_ACK, 2 RESP)
//
// Handshake: a request is outstanding from the req_tgl flip until ack_tgl
// (after synchronisation) differs from its previously seen value; exactly one
// request may be outstanding, and req_* never change while one is.
// ---------------------------------------------------------------------------
module cxapbasyncbridge_slv_hs_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLKS,
  input  logic                  PRESETSn,
  input  logic                  PSELS,
  input  logic                  PENABLES,
  input  logic                  PWRITES,
  input  logic [ADDR_WIDTH-1:0] PADDRS,
  input  logic [DATA_WIDTH-1:0] PWDATAS,
  output logic [DATA_WIDTH-1:0] PRDATAS,
  output logic                  PREADYS,
  output logic                  PSLVERRS,
  output logic                  req_tgl,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_write,
  input  logic                  ack_tgl_async,
  input  logic [DATA_WIDTH-1:0] ack_rdata,
  input  logic                  ack_slverr,
  output logic                  spurious_ack,
  output logic [1:0]            state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  ack_sync_q;
  logic                    ack_seen_q;
  logic                    ack_event;
  logic                    abort_q, abort_d;
  logic                    aborting;

  logic                    req_tgl_q, req_tgl_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic                    req_write_q, req_write_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic                    spurious_q, spurious_d;

  // Ack synchroniser; an event is any change of the synchronised level.
  always_ff @(posedge PCLKS or negedge PRESETSn) begin
    if (!PRESETSn) begin
      ack_sync_q <= '0;
      ack_seen_q <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_async};
      ack_seen_q <= ack_sync_q[SYNC_STAGES-1];
    end
  end

  assign ack_event = ack_sync_q[SYNC_STAGES-1] ^ ack_seen_q;

  // Once PSELS drops during WAIT_ACK the transfer is abandoned for good: the
  // ack is still awaited (the peer is busy) but no response is presented.
  assign aborting = abort_q | ~PSELS;

  // State register
  always_ff @(posedge PCLKS or negedge PRESETSn) begin
    if (!PRESETSn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A spurious ack takes priority and keeps the FSM idle.
        if (!ack_event && PSELS && !PENABLES) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_event) state_d = aborting ? IDLE : RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    req_tgl_d   = req_tgl_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_write_d = req_write_q;
    prdata_d    = prdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    spurious_d  = spurious_q;
    abort_d     = abort_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (ack_event) begin
          spurious_d = 1'b1;
        end else if (PSELS && !PENABLES) begin
          req_addr_d  = PADDRS;
          req_wdata_d = PWDATAS;
          req_write_d = PWRITES;
          req_tgl_d   = ~req_tgl_q;
        end
      end
      WAIT_ACK: begin
        if (ack_event) begin
          if (!aborting) begin
            pready_d  = 1'b1;
            pslverr_d = ack_slverr;
            if (!req_write_q) prdata_d = ack_rdata;
          end
        end else if (!PSELS) begin
          abort_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLKS or negedge PRESETSn) begin
    if (!PRESETSn) begin
      req_tgl_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      spurious_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      req_tgl_q   <= req_tgl_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_write_q <= req_write_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      spurious_q  <= spurious_d;
      abort_q     <= abort_d;
    end
  end

  assign PRDATAS      = prdata_q;
  assign PREADYS      = pready_q;
  assign PSLVERRS     = pslverr_q;
  assign req_tgl      = req_tgl_q;
  assign req_addr     = req_addr_q;
  assign req_wdata    = req_wdata_q;
  assign req_write    = req_write_q;
  assign spurious_ack = spurious_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_cxapbasyncbridge_slv_hs_ctrl.sv
// Bench for cxapbasyncbridge_slv_hs_ctrl: APB driver tasks, a master-domain
// peer process, and a response monitor popping an expected queue.
module tb_cxapbasyncbridge_slv_hs_ctrl;

  // ---------------- clock / reset ----------------
  logic PCLKS = 1'b0;
  logic PRESETSn = 1'b0;
  always #5 PCLKS = ~PCLKS;

  // ---------------- DUT (SYNC_STAGES=2) ----------------
  logic        PSELS = 0, PENABLES = 0, PWRITES = 0;
  logic [11:0] PADDRS = '0;
  logic [31:0] PWDATAS = '0;
  logic [31:0] PRDATAS;
  logic        PREADYS, PSLVERRS, req_tgl, req_write, spurious_ack;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        ack_tgl_async = 0, ack_slverr = 0;
  logic [31:0] ack_rdata = '0;
  logic [1:0]  state_dbg;

  cxapbasyncbridge_slv_hs_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .SYNC_STAGES(2)) u_dut (
    .PCLKS(PCLKS), .PRESETSn(PRESETSn), .PSELS(PSELS), .PENABLES(PENABLES),
    .PWRITES(PWRITES), .PADDRS(PADDRS), .PWDATAS(PWDATAS), .PRDATAS(PRDATAS),
    .PREADYS(PREADYS), .PSLVERRS(PSLVERRS), .req_tgl(req_tgl), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .ack_tgl_async(ack_tgl_async),
    .ack_rdata(ack_rdata), .ack_slverr(ack_slverr), .spurious_ack(spurious_ack),
    .state_dbg_o(state_dbg)
  );

  // ---------------- second DUT (SYNC_STAGES=3), latency only ----------------
  logic        s3_psel = 0, s3_pen = 0, s3_ack = 0;
  logic [11:0] s3_paddr = '0;
  logic [31:0] s3_rdata = '0;
  logic [31:0] s3_prdata, s3_req_wdata;
  logic        s3_pready, s3_pslverr, s3_req_tgl, s3_req_write, s3_spur;
  logic [11:0] s3_req_addr;
  logic [1:0]  s3_state;

  cxapbasyncbridge_slv_hs_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .SYNC_STAGES(3)) u_dut3 (
    .PCLKS(PCLKS), .PRESETSn(PRESETSn), .PSELS(s3_psel), .PENABLES(s3_pen),
    .PWRITES(1'b0), .PADDRS(s3_paddr), .PWDATAS(32'h0), .PRDATAS(s3_prdata),
    .PREADYS(s3_pready), .PSLVERRS(s3_pslverr), .req_tgl(s3_req_tgl), .req_addr(s3_req_addr),
    .req_wdata(s3_req_wdata), .req_write(s3_req_write), .ack_tgl_async(s3_ack),
    .ack_rdata(s3_rdata), .ack_slverr(1'b0), .spurious_ack(s3_spur),
    .state_dbg_o(s3_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          dly;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic [32:0] exp_q[$];   // {pslverr, prdata} expected at each PREADYS
  logic [44:0] req_q[$];   // {write, addr, wdata} expected at each req_tgl flip
  rsp_t        rsp_q[$];   // peer responses

  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;
  int          n_exp  = 0;
  logic [31:0] model_prdata = '0;
  logic        tgl_exp = 1'b0;
  logic        peer_en = 1'b1;
  logic        peer_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- master-domain peer ----------------
  initial begin
    logic [44:0] r;
    rsp_t        p;
    forever begin
      @(negedge PCLKS);
      if (req_tgl !== peer_last) begin
        peer_last = req_tgl;
        if (peer_en) begin
          if (req_q.size() == 0 || rsp_q.size() == 0) begin
            check("unexpected_req", 1, 0);
          end else begin
            r = req_q.pop_front();
            p = rsp_q.pop_front();
            check("req_write", req_write, r[44]);
            check("req_addr", req_addr, r[43:32]);
            check("req_wdata", req_wdata, r[31:0]);
            repeat (p.dly) @(posedge PCLKS);
            #1;
            check("req_stable", {req_write, req_addr, req_wdata}, r);
            ack_rdata     = p.rdata;
            ack_slverr    = p.err;
            ack_tgl_async = ~ack_tgl_async;
          end
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge PCLKS);
      if (PRESETSn && PREADYS) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_pready", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("prdata", PRDATAS, e[31:0]);
          check("pslverr", PSLVERRS, e[32]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input int dly, input logic [31:0] rdata, input logic err);
    rsp_t p;
    bit   done;
    p.dly = dly; p.err = err; p.rdata = rdata;
    req_q.push_back({wr, addr, wdata});
    rsp_q.push_back(p);
    if (!wr) model_prdata = rdata;
    exp_q.push_back({err, model_prdata});
    n_exp++;
    tgl_exp = ~tgl_exp;
    @(posedge PCLKS); #1;
    PSELS = 1; PENABLES = 0; PWRITES = wr; PADDRS = addr; PWDATAS = wdata;
    @(posedge PCLKS); #1;
    PENABLES = 1;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge PCLKS);
      if (PREADYS) done = 1;
    end
    if (!done) check("pready_timeout", 0, 1);
    @(posedge PCLKS); #1;
    PSELS = 0; PENABLES = 0;
    check("req_tgl", req_tgl, tgl_exp);
  endtask

  // Setup + access by hand, leaving the bench in the access phase.
  task automatic apb_start(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
    @(posedge PCLKS); #1;
    PSELS = 1; PENABLES = 0; PWRITES = wr; PADDRS = addr; PWDATAS = wdata;
    @(posedge PCLKS); #1;
    PENABLES = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prdata"}, PRDATAS, 0);
    check({tag, "_pready"}, PREADYS, 0);
    check({tag, "_pslverr"}, PSLVERRS, 0);
    check({tag, "_req_tgl"}, req_tgl, 0);
    check({tag, "_req_addr"}, req_addr, 0);
    check({tag, "_req_wdata"}, req_wdata, 0);
    check({tag, "_req_write"}, req_write, 0);
    check({tag, "_spurious"}, spurious_ack, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    bit found;

    // Reset state
    repeat (2) @(posedge PCLKS);
    #1;
    check_all_zero("reset");
    check("reset_s3_pready", s3_pready, 0);
    PRESETSn = 1;

    // T1 read
    apb_xfer(1'b0, 12'h014, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    // T2 write with error: PRDATAS keeps DEADBEEF
    apb_xfer(1'b1, 12'h020, 32'h12345678, 1, 32'hFFFF0000, 1'b1);

    // T4 back-to-back, ack delays 0 and 7
    apb_xfer(1'b0, 12'h100, 32'h0, 0, 32'h01020304, 1'b0);
    apb_xfer(1'b1, 12'h104, 32'hCAFEF00D, 7, 32'h0, 1'b0);
    apb_xfer(1'b0, 12'hFFC, 32'h0, 7, 32'h89ABCDEF, 1'b1);
    apb_xfer(1'b1, 12'h000, 32'hFFFFFFFF, 0, 32'h0, 1'b0);
    check("b2b_completions", n_done, n_exp);
    check("b2b_spurious", spurious_ack, 0);

    // T3 latency SYNC_STAGES=2: ack toggled before edge E, PREADYS after E+2
    peer_en = 0;
    model_prdata = 32'hA5A50001;
    exp_q.push_back({1'b0, model_prdata});
    n_exp++;
    tgl_exp = ~tgl_exp;
    apb_start(1'b0, 12'h2A0, 32'h0);
    @(posedge PCLKS); #1;
    ack_rdata = 32'hA5A50001; ack_slverr = 0; ack_tgl_async = ~ack_tgl_async;
    lat = 0; found = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(posedge PCLKS); #1;
      if (PREADYS) begin lat = i; found = 1; end
    end
    check("latency_s2", lat, 3);
    @(posedge PCLKS); #1;
    PSELS = 0; PENABLES = 0;
    @(negedge PCLKS);
    peer_en = 1;

    // T5 spurious ack in IDLE
    @(posedge PCLKS); #1;
    ack_tgl_async = ~ack_tgl_async;
    repeat (5) @(posedge PCLKS);
    #1;
    check("spurious_set", spurious_ack, 1);
    check("spurious_state", state_dbg, 0);

    // T5 abort: PSELS dropped in WAIT_ACK, no PREADYS, back to IDLE after ack
    begin
      rsp_t p;
      p.dly = 3; p.err = 0; p.rdata = 32'h55555555;
      req_q.push_back({1'b0, 12'h444, 32'h0});
      rsp_q.push_back(p);
      tgl_exp = ~tgl_exp;
    end
    apb_start(1'b0, 12'h444, 32'h0);
    @(posedge PCLKS); #1;
    PSELS = 0; PENABLES = 0;
    check("abort_wait_state", state_dbg, 1);
    repeat (12) @(posedge PCLKS);
    #1;
    check("abort_idle_state", state_dbg, 0);
    check("abort_prdata_kept", PRDATAS, model_prdata);
    check("abort_completions", n_done, n_exp);
    // Sequencer still usable after an abort
    apb_xfer(1'b0, 12'h448, 32'h0, 1, 32'h0BEEF000, 1'b0);

    // T6 reset mid-WAIT_ACK
    peer_en = 0;
    apb_start(1'b1, 12'h7F0, 32'hA1B2C3D4);
    @(posedge PCLKS); #2;
    check("pre_reset_state", state_dbg, 1);
    PRESETSn = 0;
    #1;
    check_all_zero("midreset");
    PSELS = 0; PENABLES = 0; ack_tgl_async = 0; ack_rdata = '0; ack_slverr = 0;
    model_prdata = '0;
    tgl_exp = 1'b0;
    repeat (2) @(posedge PCLKS);
    #3;
    PRESETSn = 1;
    @(negedge PCLKS);
    peer_en = 1;
    apb_xfer(1'b0, 12'h018, 32'h0, 2, 32'h13579BDF, 1'b0);

    // T3 latency SYNC_STAGES=3: PREADYS after E+3
    @(posedge PCLKS); #1;
    s3_psel = 1; s3_pen = 0; s3_paddr = 12'h3C0;
    @(posedge PCLKS); #1;
    s3_pen = 1;
    @(posedge PCLKS); #1;
    s3_rdata = 32'h0BADF00D; s3_ack = ~s3_ack;
    lat = 0; found = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(posedge PCLKS); #1;
      if (s3_pready) begin lat = i; found = 1; end
    end
    check("latency_s3", lat, 4);
    check("s3_prdata", s3_prdata, 32'h0BADF00D);
    check("s3_req_tgl", s3_req_tgl, 1);
    @(posedge PCLKS); #1;
    s3_psel = 0; s3_pen = 0;
    check("s3_pready_one_cycle", s3_pready, 0);

    repeat (4) @(posedge PCLKS);
    #1;
    check("final_completions", n_done, n_exp);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_spurious", spurious_ack, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
